// File: rtl/bit_calc_serial.sv
// Digit-serial bitwise/shift unit: SLICE bits per clock through one narrow
// slice datapath, START/BUSY/DONE handshake, registered result and flag.
module bit_calc_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [2:0]       SEL,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic             FLG_IN,
    output logic [WIDTH-1:0] OUT,
    output logic             FLG_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % SLICE) != 0 || WIDTH < SLICE || SLICE < 1) begin : g_bad_cfg
        $error("bit_calc_serial: WIDTH must be a nonzero multiple of SLICE");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_ANDN = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [2:0]       sel_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             zacc;

    logic [CW-1:0]    idx;
    int               base;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] r_s;
    logic             carry_nx;
    logic             zacc_nx;
    logic             flg_nx;
    logic [WIDTH-1:0] res_nx;

    always_comb begin
        // SHR walks MSB slice first so the carry moves downward
        idx = (sel_q == OP_SHR) ? (LAST - cnt) : cnt;
        base = int'(idx) * SLICE;
        a_s = a_q[base +: SLICE];
        b_s = b_q[base +: SLICE];
        r_s = '0;
        carry_nx = carry;
        unique case (sel_q)
            OP_PASS: r_s = b_s;
            OP_OR:   r_s = a_s | b_s;
            OP_AND:  r_s = a_s & b_s;
            OP_XOR:  r_s = a_s ^ b_s;
            OP_NOT:  r_s = ~b_s;
            OP_ANDN: r_s = a_s & ~b_s;
            OP_SHL: begin
                r_s = (b_s << 1) | SLICE'(carry);
                carry_nx = b_s[SLICE-1];
            end
            OP_SHR: begin
                r_s = (b_s >> 1) | (SLICE'(carry) << (SLICE - 1));
                carry_nx = b_s[0];
            end
            default: r_s = '0;
        endcase
        zacc_nx = zacc & (r_s == '0);
        res_nx = res;
        res_nx[base +: SLICE] = r_s;
        // Pass keeps FLG_IN in the untouched carry register
        unique case (sel_q)
            OP_PASS:        flg_nx = carry;
            OP_OR:          flg_nx = 1'b1;
            OP_SHL, OP_SHR: flg_nx = carry_nx;
            default:        flg_nx = zacc_nx;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res     <= '0;
            carry   <= 1'b0;
            zacc    <= 1'b1;
            OUT     <= '0;
            FLG_OUT <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        sel_q <= SEL;
                        a_q   <= IN1;
                        b_q   <= IN2;
                        carry <= FLG_IN;
                        cnt   <= '0;
                        zacc  <= 1'b1;
                        res   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    res   <= res_nx;
                    carry <= carry_nx;
                    zacc  <= zacc_nx;
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        OUT     <= res_nx;
                        FLG_OUT <= flg_nx;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY = (state != S_IDLE);
    assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_bit_calc_serial.sv
// Directed bench for bit_calc_serial: 16/4 instance for all ops and
// handshake/reset behaviour, 4/4 instance for the single-slice case.
module tb_bit_calc_serial;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [2:0]  SEL;
    logic [15:0] IN1;
    logic [15:0] IN2;
    logic        FLG_IN;
    logic [15:0] OUT;
    logic        FLG_OUT;
    logic        BUSY;
    logic        DONE;

    logic        start2;
    logic [2:0]  sel2;
    logic [3:0]  in1_2;
    logic [3:0]  in2_2;
    logic        flg_in2;
    logic [3:0]  out2;
    logic        flg_out2;
    logic        busy2;
    logic        done2;

    int n_assert = 0;
    int n_fail = 0;
    logic [15:0] last_out;
    logic        last_flg;

    bit_calc_serial #(.WIDTH(16), .SLICE(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .SEL(SEL),
        .IN1(IN1), .IN2(IN2), .FLG_IN(FLG_IN),
        .OUT(OUT), .FLG_OUT(FLG_OUT), .BUSY(BUSY), .DONE(DONE)
    );

    bit_calc_serial #(.WIDTH(4), .SLICE(4)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(start2), .SEL(sel2),
        .IN1(in1_2), .IN2(in2_2), .FLG_IN(flg_in2),
        .OUT(out2), .FLG_OUT(flg_out2), .BUSY(busy2), .DONE(done2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Issue one op, scramble inputs after capture, wait for DONE (bounded).
    task automatic do_op(input string tag, input logic [2:0] s,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic f, input logic [15:0] eo, input logic ef);
        int lat;
        SEL = s; IN1 = a; IN2 = b; FLG_IN = f; START = 1'b1;
        step();
        START = 1'b0;
        IN1 = 16'($urandom); IN2 = 16'($urandom);
        SEL = 3'($urandom_range(0, 7)); FLG_IN = ~f;
        chk({tag, "_busy"}, 32'(BUSY), 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (DONE) begin
                lat = k;
                break;
            end
            chk({tag, "_hold"}, 32'(OUT), 32'(last_out));
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_out"}, 32'(OUT), 32'(eo));
        chk({tag, "_flg"}, 32'(FLG_OUT), 32'(ef));
        last_out = eo;
        last_flg = ef;
        step();
        chk({tag, "_idle"}, {30'd0, BUSY, DONE}, 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int pulses;
        START = 0; SEL = 0; IN1 = 0; IN2 = 0; FLG_IN = 0;
        start2 = 0; sel2 = 0; in1_2 = 0; in2_2 = 0; flg_in2 = 0;
        last_out = 16'h0;
        last_flg = 1'b0;
        RST_N = 1'b0;
        #23;
        chk("rst_out", 32'(OUT), 32'd0);
        chk("rst_flags", {28'd0, FLG_OUT, BUSY, DONE, 1'b0}, 32'd0);
        chk("rst_n1", {27'd0, out2, flg_out2}, 32'd0);
        RST_N = 1'b1;
        step();

        // XOR with detailed DONE/BUSY timing
        SEL = 3'b011; IN1 = 16'hA5A5; IN2 = 16'hA5A5; FLG_IN = 0; START = 1;
        step();
        START = 0; IN1 = 16'h1111;
        busy_cnt = BUSY ? 1 : 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (BUSY) busy_cnt++;
            chk("xor_done_t", 32'(DONE), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) begin
                chk("xor_out", 32'(OUT), 32'h0000);
                chk("xor_flg", 32'(FLG_OUT), 32'd1);
            end
        end
        chk("xor_busy_cycles", busy_cnt, 5);
        last_out = 16'h0000;
        last_flg = 1'b1;

        do_op("shl",  3'b110, 16'h0000, 16'h8001, 1'b0, 16'h0002, 1'b1);
        do_op("shr",  3'b111, 16'h0000, 16'h8001, 1'b1, 16'hC000, 1'b1);
        do_op("andn", 3'b101, 16'hFFFF, 16'h00FF, 1'b0, 16'hFF00, 1'b0);
        do_op("not",  3'b100, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
        do_op("or0",  3'b001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        do_op("pass", 3'b000, 16'hFFFF, 16'h1234, 1'b1, 16'h1234, 1'b1);
        do_op("and",  3'b010, 16'h0F0F, 16'h00FF, 1'b1, 16'h000F, 1'b0);
        do_op("or1",  3'b001, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b1);

        // START held high with changing operands; captures at E0 and E6
        pulses = 0;
        for (int e = 0; e < 14; e++) begin
            if (e == 0) begin
                SEL = 3'b011; IN1 = 16'h00FF; IN2 = 16'h0F0F; FLG_IN = 0;
            end else if (e == 6) begin
                SEL = 3'b111; IN1 = 16'h0000; IN2 = 16'h0003; FLG_IN = 0;
            end else begin
                SEL = 3'($urandom_range(0, 7));
                IN1 = 16'($urandom); IN2 = 16'($urandom); FLG_IN = 1'($urandom);
            end
            START = (e <= 6);
            step();
            if (DONE) pulses++;
            chk("hold_done", 32'(DONE), (e == 4 || e == 10) ? 32'd1 : 32'd0);
            if (e == 4) chk("hold_out1", {15'd0, FLG_OUT, OUT}, {15'd0, 1'b0, 16'h0FF0});
            if (e == 10) chk("hold_out2", {15'd0, FLG_OUT, OUT}, {15'd0, 1'b1, 16'h0001});
        end
        START = 0;
        chk("hold_pulses", pulses, 2);
        last_out = 16'h0001;

        // Reset during the second RUN cycle
        SEL = 3'b000; IN2 = 16'hBEEF; FLG_IN = 1; START = 1;
        step();
        START = 0;
        step();
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_out", {15'd0, FLG_OUT, OUT}, 32'd0);
        chk("arst_hs", {30'd0, BUSY, DONE}, 32'd0);
        step();
        RST_N = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (DONE || BUSY) pulses++;
        end
        chk("arst_nodone", pulses, 0);
        chk("arst_out_kept", 32'(OUT), 32'd0);
        last_out = 16'h0000;
        do_op("post_rst", 3'b011, 16'h1234, 16'h4321, 1'b0, 16'h5115, 1'b0);

        // Single-slice instance
        sel2 = 3'b010; in1_2 = 4'hC; in2_2 = 4'h3; flg_in2 = 0; start2 = 1;
        step();
        start2 = 0; in1_2 = 4'hF; in2_2 = 4'hF;
        chk("n1_busy", {30'd0, busy2, done2}, 32'd2);
        step();
        chk("n1_done", 32'(done2), 32'd1);
        chk("n1_out", {27'd0, flg_out2, out2}, {27'd0, 1'b1, 4'h0});
        step();
        chk("n1_idle", {30'd0, busy2, done2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
